// File: rtl/toy_bus_slv_node_reg_pkg.sv
// Shared constants and region-map helpers for the toy bus slave node.
package toy_bus_slv_node_reg_pkg;
   localparam int   ID_W     = 4;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   // One region-map entry is {base, limit, tgt}.
   function automatic int rgn_entry_w(input int addr_w);
      return 2 * addr_w + ID_W;
   endfunction

   // Region 0 sits in the MSBs of the packed map.
   function automatic int rgn_lsb(input int idx, input int num_rgn, input int addr_w);
      return (num_rgn - 1 - idx) * rgn_entry_w(addr_w);
   endfunction
endpackage

// File: rtl/toy_bus_slv_node_reg_if.sv
// Request/ack channel bundle; master issues requests and consumes acks.
interface toy_bus_slv_node_reg_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int SB_W   = 10
);
   import toy_bus_slv_node_reg_pkg::*;
   localparam int STRB_W = DATA_W / 8;

   logic              req_vld;
   logic              req_rdy;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [STRB_W-1:0] req_strb;
   logic              req_opcode;
   logic [SB_W-1:0]   req_sideband;
   logic [ID_W-1:0]   req_src_id;
   logic [ID_W-1:0]   req_tgt_id;
   logic              ack_vld;
   logic              ack_rdy;
   logic [DATA_W-1:0] ack_data;
   logic [SB_W-1:0]   ack_sideband;
   logic [ID_W-1:0]   ack_tgt_id;

   modport master (
      output req_vld, req_addr, req_data, req_strb, req_opcode, req_sideband,
             req_src_id, req_tgt_id, ack_rdy,
      input  req_rdy, ack_vld, ack_data, ack_sideband, ack_tgt_id
   );
   modport slave (
      input  req_vld, req_addr, req_data, req_strb, req_opcode, req_sideband,
             req_src_id, req_tgt_id, ack_rdy,
      output req_rdy, ack_vld, ack_data, ack_sideband, ack_tgt_id
   );
endinterface

// File: rtl/toy_bus_slv_node_reg_skid_fifo2.sv
// Two-entry FIFO with registered state; ready depends only on the fill count.
module toy_bus_skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         not_full,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data
);
   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   logic [1:0]   cnt_reg;
   logic         pop;

   assign not_full = (cnt_reg != 2'd2);
   assign out_vld  = (cnt_reg != 2'd0);
   assign out_data = mem_reg[rd_ptr_reg];
   assign pop      = out_vld && out_rdy;

   // Caller only pushes while not_full, so a full FIFO never admits on a pop cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         cnt_reg    <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         cnt_reg <= cnt_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_reg[wr_ptr_reg] <= push_data;
   end
endmodule

// File: rtl/toy_bus_slv_node_reg.sv
// Fetch-side slave node: region decode, buffered request/ack paths,
// outstanding-transaction limit and sticky misroute flag.
module toy_bus_slv_node_reg
   import toy_bus_slv_node_reg_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 256,
   parameter int              SB_W     = 10,
   parameter logic [ID_W-1:0] SRC_ID   = 4'd0,
   parameter logic [ID_W-1:0] DFLT_TGT = 4'd4,
   parameter int              NUM_RGN  = 2,
   parameter logic [NUM_RGN*(2*ADDR_W+ID_W)-1:0] RGN_MAP =
      {32'h8000_0000, 32'hA000_0000, 4'd2, 32'hA000_0000, 32'hC000_0000, 4'd3},
   parameter int              MAX_OST  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   toy_bus_slv_node_reg_if.slave         in0,
   toy_bus_slv_node_reg_if.master        out0,
   output logic                          err_misroute
);
   localparam int STRB_W = DATA_W / 8;
   localparam int RGN_W  = rgn_entry_w(ADDR_W);
   localparam int REQ_W  = ADDR_W + STRB_W + DATA_W + 1 + SB_W + ID_W;
   localparam int ACK_W  = DATA_W + SB_W;
   localparam int OST_W  = $clog2(MAX_OST + 1);

   logic [NUM_RGN-1:0] rgn_hit;
   logic [ID_W-1:0]    rgn_tgt [NUM_RGN];
   logic [ID_W-1:0]    dec_tgt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RGN; gi++) begin : g_rgn
         localparam int                LSB   = rgn_lsb(gi, NUM_RGN, ADDR_W);
         localparam logic [RGN_W-1:0]  ENTRY = RGN_MAP[LSB +: RGN_W];
         localparam logic [ADDR_W-1:0] BASE  = ENTRY[RGN_W-1 -: ADDR_W];
         localparam logic [ADDR_W-1:0] LIMIT = ENTRY[ID_W +: ADDR_W];
         assign rgn_hit[gi] = (in0.req_addr >= BASE) && (in0.req_addr < LIMIT);
         assign rgn_tgt[gi] = ENTRY[ID_W-1:0];
      end
   endgenerate

   // Walk from the highest index down so the lowest matching region wins.
   always_comb begin
      dec_tgt = DFLT_TGT;
      for (int i = NUM_RGN - 1; i >= 0; i--) begin
         if (rgn_hit[i]) dec_tgt = rgn_tgt[i];
      end
   end

   logic             req_not_full, req_rdy, req_hs, req_out_vld;
   logic [REQ_W-1:0] req_push_data, req_out_data;
   logic             ack_not_full, ack_push, ack_hs, ack_out_vld, ack_id_ok;
   logic [ACK_W-1:0] ack_out_data;
   logic [OST_W-1:0] ost_cnt_reg, ost_cnt_next;
   logic             err_misroute_reg, err_set;
   logic             unused_ids;

   assign req_rdy       = req_not_full && (ost_cnt_reg < OST_W'(MAX_OST));
   assign req_hs        = in0.req_vld && req_rdy;
   assign req_push_data = {in0.req_addr, in0.req_strb, in0.req_data, in0.req_opcode,
                           in0.req_sideband, dec_tgt};

   toy_bus_skid_fifo2 #(.W(REQ_W)) u_req_fifo (
      .clk(clk), .rst_n(rst_n), .push(req_hs), .push_data(req_push_data),
      .not_full(req_not_full), .out_vld(req_out_vld), .out_rdy(out0.req_rdy),
      .out_data(req_out_data)
   );

   assign in0.req_rdy     = req_rdy;
   assign out0.req_vld    = req_out_vld;
   assign out0.req_src_id = SRC_ID;
   assign {out0.req_addr, out0.req_strb, out0.req_data, out0.req_opcode,
           out0.req_sideband, out0.req_tgt_id} = req_out_data;

   // Acks for another node are consumed here but never forwarded to the core.
   assign ack_id_ok = (out0.ack_tgt_id == SRC_ID);
   assign ack_push  = out0.ack_vld && ack_not_full && ack_id_ok;

   toy_bus_skid_fifo2 #(.W(ACK_W)) u_ack_fifo (
      .clk(clk), .rst_n(rst_n), .push(ack_push),
      .push_data({out0.ack_data, out0.ack_sideband}),
      .not_full(ack_not_full), .out_vld(ack_out_vld), .out_rdy(in0.ack_rdy),
      .out_data(ack_out_data)
   );

   assign out0.ack_rdy = ack_not_full;
   assign in0.ack_vld  = ack_out_vld;
   assign in0.ack_tgt_id = SRC_ID;
   assign {in0.ack_data, in0.ack_sideband} = ack_out_data;
   assign ack_hs = ack_out_vld && in0.ack_rdy;

   always_comb begin
      ost_cnt_next = ost_cnt_reg;
      err_set      = out0.ack_vld && ack_not_full && !ack_id_ok;
      if (req_hs && !ack_hs) begin
         ost_cnt_next = ost_cnt_reg + OST_W'(1);
      end else if (ack_hs && !req_hs) begin
         if (ost_cnt_reg == '0) err_set = 1'b1;
         else                   ost_cnt_next = ost_cnt_reg - OST_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ost_cnt_reg      <= '0;
         err_misroute_reg <= 1'b0;
      end else begin
         ost_cnt_reg <= ost_cnt_next;
         if (err_set) err_misroute_reg <= 1'b1;
      end
   end

   assign err_misroute = err_misroute_reg;
   assign unused_ids   = ^{in0.req_src_id, in0.req_tgt_id};
endmodule

// File: tb/tb_toy_bus_slv_node_reg.sv
// Scoreboard bench for the toy bus slave node: decode table plus hand-written
// backpressure, outstanding-limit, misroute and reset sequences.
module tb_toy_bus_slv_node_reg;
   import toy_bus_slv_node_reg_pkg::*;

   localparam int         ADDR_W  = 32;
   localparam int         DATA_W  = 256;
   localparam int         SB_W    = 10;
   localparam logic [3:0] SRC_ID  = 4'd0;
   localparam int         MAX_OST = 8;
   localparam int         RW      = 339;

   typedef struct {
      logic [31:0]  addr;
      logic [31:0]  strb;
      logic [255:0] data;
      logic         op;
      logic [9:0]   sb;
      logic [3:0]   tgt;
   } exp_req_t;

   typedef struct {
      logic [255:0] data;
      logic [9:0]   sb;
   } exp_ack_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  exp_tgt;
   } dec_vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic err_misroute;
   always #5 clk = ~clk;

   toy_bus_slv_node_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_W(SB_W)) in0_if ();
   toy_bus_slv_node_reg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_W(SB_W)) out0_if ();

   toy_bus_slv_node_reg #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_W(SB_W), .SRC_ID(SRC_ID), .MAX_OST(MAX_OST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in0(in0_if), .out0(out0_if), .err_misroute(err_misroute)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          bus_acc_cnt = 0;
   logic [31:0] seq  = 32'h1000_0000;
   logic [31:0] aseq = 32'h0000_0100;
   exp_req_t    exp_req_q[$];
   exp_ack_t    exp_ack_q[$];
   exp_req_t    er;
   exp_ack_t    ea;
   logic [RW-1:0] cur_req, held_req;
   bit          stall;
   dec_vec_t    dec_tab [6];
   int          base;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [3:0] ref_tgt(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'hA000_0000) return 4'd2;
      if (a >= 32'hA000_0000 && a < 32'hC000_0000) return 4'd3;
      return 4'd4;
   endfunction

   function automatic logic [31:0] thr_addr(input int k);
      return 32'h8000_0000 + 32'(k) * 32'h0800_0000;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_req(input logic [31:0] addr, input logic op, input logic [3:0] etgt);
      exp_req_t e;
      bit ok = 1'b0;
      seq = seq + 32'h0001_0003;
      e.addr = addr; e.strb = ~seq; e.data = {8{seq}}; e.op = op; e.sb = seq[9:0]; e.tgt = etgt;
      in0_if.req_vld = 1'b1; in0_if.req_addr = addr; in0_if.req_strb = e.strb;
      in0_if.req_data = e.data; in0_if.req_opcode = op; in0_if.req_sideband = e.sb;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (in0_if.req_rdy) begin ok = 1'b1; break; end
      end
      if (ok) exp_req_q.push_back(e);
      else check("req_accept_timeout", in0_if.req_rdy, 1'b1);
      @(posedge clk);
      #1;
      in0_if.req_vld = 1'b0;
   endtask

   task automatic send_ack(input logic [3:0] tgt);
      exp_ack_t e;
      bit ok = 1'b0;
      aseq = aseq + 32'h0000_0021;
      e.data = {8{aseq ^ 32'h5A5A_0000}}; e.sb = aseq[9:0];
      out0_if.ack_vld = 1'b1; out0_if.ack_tgt_id = tgt;
      out0_if.ack_data = e.data; out0_if.ack_sideband = e.sb;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (out0_if.ack_rdy) begin ok = 1'b1; break; end
      end
      if (!ok) check("ack_accept_timeout", out0_if.ack_rdy, 1'b1);
      else if (tgt == SRC_ID) exp_ack_q.push_back(e);
      @(posedge clk);
      #1;
      out0_if.ack_vld = 1'b0;
   endtask

   task automatic wait_acc(input int n);
      for (int c = 0; c < 300; c++) begin
         if (bus_acc_cnt >= n) return;
         @(posedge clk);
         #1;
      end
      check("bus_accept_timeout", bus_acc_cnt, n);
   endtask

   // Bus-side request monitor: order/payload scoreboard and stall stability.
   initial begin
      stall = 1'b0;
      forever begin
         @(negedge clk);
         cur_req = {out0_if.req_addr, out0_if.req_strb, out0_if.req_data, out0_if.req_opcode,
                    out0_if.req_sideband, out0_if.req_tgt_id, out0_if.req_src_id};
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("req_hold_vld", out0_if.req_vld, 1'b1);
               check("req_hold_payload", cur_req, held_req);
            end
            stall    = out0_if.req_vld && !out0_if.req_rdy;
            held_req = cur_req;
            if (out0_if.req_vld && out0_if.req_rdy) begin
               bus_acc_cnt++;
               if (exp_req_q.size() == 0) begin
                  check("req_unexpected", out0_if.req_vld, 1'b0);
               end else begin
                  er = exp_req_q.pop_front();
                  check("req_payload", cur_req,
                        {er.addr, er.strb, er.data, er.op, er.sb, er.tgt, SRC_ID});
                  $display("req  addr=%h op=%0d tgt=%0d src=%0d", out0_if.req_addr,
                           out0_if.req_opcode, out0_if.req_tgt_id, out0_if.req_src_id);
               end
            end
         end
      end
   end

   // Core-side ack monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && in0_if.ack_vld && in0_if.ack_rdy) begin
            if (exp_ack_q.size() == 0) begin
               check("ack_unexpected", in0_if.ack_vld, 1'b0);
            end else begin
               ea = exp_ack_q.pop_front();
               check("ack_payload", {in0_if.ack_data, in0_if.ack_sideband}, {ea.data, ea.sb});
               $display("ack  data=%h sb=%h", in0_if.ack_data[31:0], in0_if.ack_sideband);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      dec_tab[0] = '{32'h8000_0000, 4'd2};
      dec_tab[1] = '{32'h9FFF_FFFF, 4'd2};
      dec_tab[2] = '{32'hA000_0000, 4'd3};
      dec_tab[3] = '{32'hBFFF_FFFF, 4'd3};
      dec_tab[4] = '{32'hC000_0000, 4'd4};
      dec_tab[5] = '{32'h0000_0000, 4'd4};

      rst_n = 1'b0;
      in0_if.req_vld = 1'b0; in0_if.req_addr = '0; in0_if.req_data = '0; in0_if.req_strb = '0;
      in0_if.req_opcode = 1'b0; in0_if.req_sideband = '0;
      in0_if.req_src_id = '0; in0_if.req_tgt_id = '0; in0_if.ack_rdy = 1'b1;
      out0_if.req_rdy = 1'b0; out0_if.ack_vld = 1'b0; out0_if.ack_data = '0;
      out0_if.ack_sideband = '0; out0_if.ack_tgt_id = '0;

      // Reset state
      #12;
      check("rst_out0_req_vld", out0_if.req_vld, 1'b0);
      check("rst_in0_ack_vld", in0_if.ack_vld, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("rst_in0_req_rdy", in0_if.req_rdy, 1'b1);
      check("rst_out0_ack_rdy", out0_if.ack_rdy, 1'b1);
      check("rst_err", err_misroute, 1'b0);
      check("rst_ost", dut.ost_cnt_reg, 0);

      // Address decode table, latency 1 after acceptance
      out0_if.req_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_req(dec_tab[i].addr, OP_READ, dec_tab[i].exp_tgt);
         check("dec_latency_vld", out0_if.req_vld, 1'b1);
         check("dec_tgt", out0_if.req_tgt_id, dec_tab[i].exp_tgt);
      end
      tick(3);
      for (int i = 0; i < 6; i++) send_ack(SRC_ID);
      tick(4);
      check("dec_ost_drained", dut.ost_cnt_reg, 0);

      // Throughput with out0 ready toggling every cycle
      base = bus_acc_cnt;
      fork
         begin
            for (int k = 0; k < 10; k++) send_req(thr_addr(k), OP_READ, ref_tgt(thr_addr(k)));
         end
         begin
            for (int c = 0; c < 200 && bus_acc_cnt < base + 10; c++) begin
               @(posedge clk);
               #1;
               out0_if.req_rdy = ~out0_if.req_rdy;
            end
            out0_if.req_rdy = 1'b1;
         end
         begin
            for (int k = 0; k < 10; k++) begin
               wait_acc(base + k + 1);
               send_ack(SRC_ID);
            end
         end
      join
      tick(5);
      check("thr_count", bus_acc_cnt, base + 10);
      check("thr_req_q_empty", exp_req_q.size(), 0);
      check("thr_ack_q_empty", exp_ack_q.size(), 0);
      check("thr_ost", dut.ost_cnt_reg, 0);

      // Outstanding limit
      out0_if.req_rdy = 1'b1;
      for (int k = 0; k < MAX_OST; k++) send_req(32'h0000_1000 + 32'(k), OP_WRITE, 4'd4);
      check("ost_rdy_low_at_max", in0_if.req_rdy, 1'b0);
      check("ost_at_max", dut.ost_cnt_reg, MAX_OST);
      tick(2);
      check("ost_rdy_still_low", in0_if.req_rdy, 1'b0);
      send_ack(SRC_ID);
      check("ost_rdy_before_core_ack", in0_if.req_rdy, 1'b0);
      tick(1);
      check("ost_rdy_after_core_ack", in0_if.req_rdy, 1'b1);
      send_req(32'h0000_2000, OP_WRITE, 4'd4);
      check("ost_ninth_at_max", dut.ost_cnt_reg, MAX_OST);
      check("ost_ninth_rdy_low", in0_if.req_rdy, 1'b0);
      for (int k = 0; k < MAX_OST; k++) send_ack(SRC_ID);
      tick(4);
      check("ost_drained", dut.ost_cnt_reg, 0);
      check("ost_ack_q_empty", exp_ack_q.size(), 0);

      // Misroute
      send_req(32'hA000_0040, OP_READ, 4'd3);
      tick(3);
      check("mis_err_before", err_misroute, 1'b0);
      check("mis_ack_rdy", out0_if.ack_rdy, 1'b1);
      send_ack(4'd5);
      for (int c = 0; c < 3; c++) begin
         check("mis_no_core_ack", in0_if.ack_vld, 1'b0);
         tick(1);
      end
      check("mis_err_set", err_misroute, 1'b1);
      check("mis_ost_unchanged", dut.ost_cnt_reg, 1);
      send_ack(SRC_ID);
      tick(3);
      check("mis_err_sticky", err_misroute, 1'b1);
      check("mis_ost_after_good", dut.ost_cnt_reg, 0);

      // Reset with two requests buffered and three outstanding
      out0_if.req_rdy = 1'b1;
      send_req(32'h8000_0100, OP_READ, 4'd2);
      tick(2);
      out0_if.req_rdy = 1'b0;
      send_req(32'h8000_0200, OP_READ, 4'd2);
      send_req(32'h8000_0300, OP_READ, 4'd2);
      check("rmid_fifo_full_rdy", in0_if.req_rdy, 1'b0);
      check("rmid_ost_three", dut.ost_cnt_reg, 3);
      #1;
      rst_n = 1'b0;
      #1;
      check("rmid_req_vld_async", out0_if.req_vld, 1'b0);
      check("rmid_ack_vld_async", in0_if.ack_vld, 1'b0);
      exp_req_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("rmid_ost_zero", dut.ost_cnt_reg, 0);
      check("rmid_err_cleared", err_misroute, 1'b0);
      check("rmid_rdy", in0_if.req_rdy, 1'b1);
      base = bus_acc_cnt;
      out0_if.req_rdy = 1'b1;
      send_req(32'hB000_0000, OP_WRITE, 4'd3);
      wait_acc(base + 1);
      tick(2);
      check("rmid_new_req_delivered", bus_acc_cnt, base + 1);
      check("rmid_req_q_empty", exp_req_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
